// File: rtl/lc3b_line_adapter_pkg.sv
// Shared types for the LC-3b line adapter: FSM state encoding and default line typedefs.
package lc3b_types;

   localparam int LC3B_LINE_WORDS = 8;
   localparam int LC3B_WORD_W     = 16;
   localparam int LC3B_LINE_W     = LC3B_WORD_W * LC3B_LINE_WORDS;
   localparam int LC3B_BE_W       = LC3B_LINE_W / 8;

   typedef logic [LC3B_LINE_W-1:0] lc3b_line;
   typedef logic [LC3B_BE_W-1:0]   lc3b_line_be;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } lc3b_state_e;

endpackage

// File: rtl/lc3b_line_adapter_if.sv
// CPU word port and cache-line port of the LC-3b line adapter, bundled in one interface.
interface lc3b_line_adapter_if #(
   parameter int ADDR_W     = 16,
   parameter int WORD_W     = 16,
   parameter int LINE_WORDS = 8
);
   localparam int LINE_W = WORD_W * LINE_WORDS;
   localparam int BE_W   = LINE_W / 8;

   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_byte;
   logic [ADDR_W-1:0] cpu_addr;
   logic [WORD_W-1:0] cpu_wdata;
   logic [WORD_W-1:0] cpu_rdata;
   logic              cpu_resp;
   logic              line_read;
   logic              line_write;
   logic [ADDR_W-1:0] line_addr;
   logic [LINE_W-1:0] line_wdata;
   logic [BE_W-1:0]   line_be;
   logic [LINE_W-1:0] line_rdata;
   logic              line_resp;

   // adapter side
   modport master (
      input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, line_rdata, line_resp,
      output cpu_rdata, cpu_resp, line_read, line_write, line_addr, line_wdata, line_be
   );

   // core + cache side
   modport slave (
      output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, line_rdata, line_resp,
      input  cpu_rdata, cpu_resp, line_read, line_write, line_addr, line_wdata, line_be
   );
endinterface

// File: rtl/lc3b_line_adapter_lane_sel.sv
// Combinational lane logic: word/byte extract from a line, word/byte insert into a line,
// and byte-enable generation.
module lc3b_lane_sel #(
   parameter int WORD_W     = 16,
   parameter int LINE_WORDS = 8
) (
   input  logic [$clog2(LINE_WORDS)-1:0]  wsel,
   input  logic [$clog2(WORD_W/8)-1:0]    bsel,
   input  logic                           byte_acc,
   input  logic [WORD_W-1:0]              wdata,
   input  logic [WORD_W*LINE_WORDS-1:0]   line_in,
   output logic [WORD_W-1:0]              rdata,
   output logic [WORD_W*LINE_WORDS-1:0]   line_out,
   output logic [WORD_W*LINE_WORDS/8-1:0] be
);
   localparam int BPW = WORD_W / 8;

   int                woff_s;
   int                boff_s;
   logic [WORD_W-1:0] word_s;
   logic [WORD_W-1:0] lane_s;

   // extract, insert and enable generation for the selected lane
   always_comb begin
      woff_s   = int'(wsel) * WORD_W;
      boff_s   = int'(wsel) * BPW + int'(bsel);
      word_s   = line_in[woff_s +: WORD_W];
      line_out = '0;
      be       = '0;
      if (byte_acc) begin
         rdata  = {{(WORD_W-8){1'b0}}, word_s[int'(bsel)*8 +: 8]};
         lane_s = {BPW{wdata[7:0]}};
         be[boff_s] = 1'b1;
      end else begin
         rdata  = word_s;
         lane_s = wdata;
         be[int'(wsel)*BPW +: BPW] = {BPW{1'b1}};
      end
      line_out[woff_s +: WORD_W] = lane_s;
   end
endmodule

// File: rtl/lc3b_line_adapter.sv
// LC-3b MAR/MDR word port to cache-line bus adapter (IDLE -> ACCESS -> RESP).
// Optional one-entry line buffer: define LC3B_LINE_ADAPTER_LINEBUF_EN.
module lc3b_line_adapter
   import lc3b_types::*;
#(
   parameter int ADDR_W     = 16,
   parameter int WORD_W     = 16,
   parameter int LINE_WORDS = LC3B_LINE_WORDS
) (
   input logic               clk,
   input logic               rst_n,
   lc3b_line_adapter_if.master bus
);
   localparam int LINE_W = WORD_W * LINE_WORDS;
   localparam int BE_W   = LINE_W / 8;
   localparam int WSEL_W = $clog2(LINE_WORDS);
   localparam int BSEL_W = $clog2(WORD_W / 8);
   localparam int OFF_W  = WSEL_W + BSEL_W;

   lc3b_state_e       state_r, next_s;
   logic [ADDR_W-1:0] addr_r;
   logic              we_r, byte_r;
   logic [WORD_W-1:0] wdata_r, rdata_r;
   logic              hit_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic              sel_byte_s;
   logic [LINE_W-1:0] sel_line_s;
   logic [WORD_W-1:0] ext_s;
   logic [LINE_W-1:0] ins_s;
   logic [BE_W-1:0]   be_s;

   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
      return a & ({ADDR_W{1'b1}} << OFF_W);
   endfunction

`ifdef LC3B_LINE_ADAPTER_LINEBUF_EN
   logic              buf_valid_r;
   logic [ADDR_W-1:0] buf_tag_r;
   logic [LINE_W-1:0] buf_data_r;

   // in IDLE the lane logic looks at the live request so a buffer hit can be served at once
   always_comb begin
      hit_s = (state_r == S_IDLE) && bus.cpu_req && !bus.cpu_we && buf_valid_r &&
              (buf_tag_r == line_base(bus.cpu_addr));
      if (state_r == S_IDLE) begin
         sel_addr_s = bus.cpu_addr;
         sel_byte_s = bus.cpu_byte;
         sel_line_s = buf_data_r;
      end else begin
         sel_addr_s = addr_r;
         sel_byte_s = byte_r;
         sel_line_s = bus.line_rdata;
      end
   end

   // line buffer: fill on completed reads, merge completed stores to the same line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_r <= 1'b0;
         buf_tag_r   <= '0;
         buf_data_r  <= '0;
      end else if (state_r == S_ACCESS && bus.line_resp) begin
         if (!we_r) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= line_base(addr_r);
            buf_data_r  <= bus.line_rdata;
         end else if (buf_valid_r && buf_tag_r == line_base(addr_r)) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be_s[i]) buf_data_r[i*8 +: 8] <= ins_s[i*8 +: 8];
            end
         end
      end
   end
`else
   // lane logic always works from the latched request
   always_comb begin
      hit_s      = 1'b0;
      sel_addr_s = addr_r;
      sel_byte_s = byte_r;
      sel_line_s = bus.line_rdata;
   end
`endif

   lc3b_lane_sel #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) u_lane_sel (
      .wsel     (sel_addr_s[BSEL_W +: WSEL_W]),
      .bsel     (sel_addr_s[BSEL_W-1:0]),
      .byte_acc (sel_byte_s),
      .wdata    (wdata_r),
      .line_in  (sel_line_s),
      .rdata    (ext_s),
      .line_out (ins_s),
      .be       (be_s)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= next_s;
   end

   // next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE:   if (bus.cpu_req) next_s = hit_s ? S_RESP : S_ACCESS; else next_s = S_IDLE;
         S_ACCESS: if (bus.line_resp) next_s = S_RESP; else next_s = S_ACCESS;
         S_RESP:   next_s = S_IDLE;
         default:  next_s = S_IDLE;
      endcase
   end

   // output decode; enables only ever qualify a write
   always_comb begin
      bus.line_read  = (state_r == S_ACCESS) && !we_r;
      bus.line_write = (state_r == S_ACCESS) && we_r;
      bus.cpu_resp   = (state_r == S_RESP);
      bus.cpu_rdata  = rdata_r;
      bus.line_addr  = line_base(addr_r);
      bus.line_wdata = ins_s;
      if (bus.line_write) bus.line_be = be_s;
      else                bus.line_be = '0;
   end

   // request latch and load-data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r  <= '0;
         we_r    <= 1'b0;
         byte_r  <= 1'b0;
         wdata_r <= '0;
         rdata_r <= '0;
      end else begin
         if (state_r == S_IDLE && bus.cpu_req) begin
            addr_r  <= bus.cpu_addr;
            we_r    <= bus.cpu_we;
            byte_r  <= bus.cpu_byte;
            wdata_r <= bus.cpu_wdata;
         end
         if ((state_r == S_ACCESS && bus.line_resp && !we_r) || hit_s) rdata_r <= ext_s;
      end
   end
endmodule

// File: tb/tb_lc3b_line_adapter.sv
// Self-checking bench for lc3b_line_adapter: byte-addressed memory reference model,
// cache responder with random latency, directed and randomized accesses.
module tb_lc3b_line_adapter;
   logic clk;
   logic rst_n;

   lc3b_line_adapter_if #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(8)) bus ();

   lc3b_line_adapter #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   ref_mem   [0:65535];
   logic [7:0]   cache_mem [0:65535];
   logic [15:0]  last_load = 16'h0000;
   bit           buf_valid = 1'b0;
   logic [15:0]  buf_tag   = 16'h0000;
   logic [15:0]  last_be;
   logic [127:0] last_wd;
   int           last_resp_at;
   bit           last_issued;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_access(input bit we, input bit byt, input logic [15:0] addr,
                            input logic [15:0] wdata, input int lat);
      bit           hit_exp, issued, done;
      int           cyc, acc, resp_at, exp_resp;
      logic [15:0]  base, exp_rd, exp_be, wa;
      logic [127:0] exp_wd, rline;
      base    = addr & 16'hFFF0;
      wa      = addr & 16'hFFFE;
      exp_rd  = byt ? {8'h00, ref_mem[addr]} : {ref_mem[wa + 16'd1], ref_mem[wa]};
      hit_exp = 1'b0;
`ifdef LC3B_LINE_ADAPTER_LINEBUF_EN
      hit_exp = !we && buf_valid && (buf_tag == base);
`endif
      exp_resp = hit_exp ? 1 : lat + 2;
      exp_be   = byt ? (16'd1 << addr[3:0]) : (16'd3 << {addr[3:1], 1'b0});
      exp_wd   = '0;
      for (int i = 0; i < 16; i++) begin
         if ((i / 2) == int'(addr[3:1]))
            exp_wd[i*8 +: 8] = (byt || (i % 2 == 0)) ? wdata[7:0] : wdata[15:8];
      end
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_byte = byt;
      bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.line_resp = 1'b0;
      cyc = 0; acc = 0; resp_at = -1; issued = 1'b0; done = 1'b0;
      while (!done && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (bus.cpu_resp) begin
            resp_at = cyc; done = 1'b1;
            if (!we) chk("load_data", bus.cpu_rdata, exp_rd);
            else     chk("store_keeps_rdata", bus.cpu_rdata, last_load);
            bus.cpu_req = 1'b0; bus.line_resp = 1'b0;
         end else if (bus.line_read || bus.line_write) begin
            issued = 1'b1; acc++;
            chk("line_dir", bus.line_read, !we);
            chk("line_addr", bus.line_addr, base);
            if (bus.line_write) begin
               chk("line_be", bus.line_be, exp_be);
               chk("line_wdata", bus.line_wdata, exp_wd);
               last_be = bus.line_be; last_wd = bus.line_wdata;
            end else begin
               chk("be_zero_on_read", bus.line_be, 16'h0000);
            end
            bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
            bus.cpu_we = 1'($urandom); bus.cpu_byte = 1'($urandom);
            if (acc == lat + 1) begin
               bus.line_resp = 1'b1;
               if (bus.line_write) begin
                  for (int i = 0; i < 16; i++)
                     if (bus.line_be[i]) cache_mem[bus.line_addr + 16'(i)] = bus.line_wdata[i*8 +: 8];
               end else begin
                  for (int i = 0; i < 16; i++) rline[i*8 +: 8] = cache_mem[bus.line_addr + 16'(i)];
                  bus.line_rdata = rline;
               end
            end else begin
               bus.line_resp  = 1'b0;
               bus.line_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
         end else begin
            bus.line_resp = 1'b0;
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL resp_timeout actual=none expected=cpu_resp within 30 cycles");
         bus.cpu_req = 1'b0; bus.line_resp = 1'b0;
      end
      @(negedge clk);
      chk("resp_single", bus.cpu_resp, 1'b0);
      chk("line_idle", {bus.line_read, bus.line_write}, 2'b00);
      chk("latency", resp_at, exp_resp);
      chk("line_issue", issued, !hit_exp);
      last_resp_at = resp_at; last_issued = issued;
      if (we) begin
         if (byt) ref_mem[addr] = wdata[7:0];
         else begin ref_mem[wa] = wdata[7:0]; ref_mem[wa + 16'd1] = wdata[15:8]; end
      end else begin
         last_load = exp_rd;
         if (!hit_exp) begin buf_valid = 1'b1; buf_tag = base; end
      end
   endtask

   task automatic test_reset;
      #1;
      chk("rst_line_read", bus.line_read, 1'b0);
      chk("rst_line_write", bus.line_write, 1'b0);
      chk("rst_cpu_resp", bus.cpu_resp, 1'b0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
      chk("rst_line_addr", bus.line_addr, 16'h0000);
      chk("rst_line_be", bus.line_be, 16'h0000);
      chk("rst_line_wdata", bus.line_wdata, 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_access;
      bit seen;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0; bus.cpu_addr = 16'h1236;
      bus.line_resp = 1'b0;
      @(negedge clk);
      chk("mid_line_read", bus.line_read, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_line_read", bus.line_read, 1'b0);
      chk("mid_rst_cpu_resp", bus.cpu_resp, 1'b0);
      chk("mid_rst_rdata", bus.cpu_rdata, 16'h0000);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.cpu_resp || bus.line_read) seen = 1'b1;
      end
      chk("mid_rst_no_resp", seen, 1'b0);
      last_load = 16'h0000; buf_valid = 1'b0;
   endtask

   task automatic test_stray_resp;
      bit seen;
      seen = 1'b0;
      bus.line_resp = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.cpu_resp || bus.line_read || bus.line_write) seen = 1'b1;
      end
      bus.line_resp = 1'b0;
      chk("stray_resp_ignored", seen, 1'b0);
   endtask

   task automatic test_loads;
      do_access(1'b0, 1'b0, 16'h1236, 16'h0000, 2);
      chk("word_load_beef", bus.cpu_rdata, 16'hBEEF);
      do_access(1'b0, 1'b1, 16'h1237, 16'h0000, 1);
      chk("byte_load_hi", bus.cpu_rdata, 16'h00BE);
      do_access(1'b0, 1'b1, 16'h1236, 16'h0000, 3);
      chk("byte_load_lo", bus.cpu_rdata, 16'h00EF);
   endtask

   task automatic test_stores;
      do_access(1'b1, 1'b0, 16'h0004, 16'hA5C3, 1);
      chk("word_store_be", last_be, 16'h0030);
      chk("word_store_lane", last_wd[47:32], 16'hA5C3);
      chk("word_store_rest", last_wd & ~(128'hFFFF << 32), 128'h0);
      do_access(1'b1, 1'b1, 16'h0009, 16'h0077, 0);
      chk("byte_store_be", last_be, 16'h0200);
      chk("byte_store_lane", last_wd[79:64], 16'h7777);
   endtask

   task automatic test_min_latency;
      do_access(1'b0, 1'b0, 16'h0040, 16'h0000, 0);
      chk("min_latency", last_resp_at, 2);
   endtask

   task automatic test_linebuf;
      do_access(1'b0, 1'b0, 16'h1236, 16'h0000, 1);
      do_access(1'b0, 1'b0, 16'h1236, 16'h0000, 1);
      chk("repeat_load_data", bus.cpu_rdata, 16'hBEEF);
`ifdef LC3B_LINE_ADAPTER_LINEBUF_EN
      chk("repeat_load_latency", last_resp_at, 1);
      chk("repeat_load_no_read", last_issued, 1'b0);
`else
      chk("repeat_load_latency", last_resp_at, 3);
      chk("repeat_load_read", last_issued, 1'b1);
`endif
   endtask

   task automatic test_random;
      for (int n = 0; n < 60; n++) begin
         logic [15:0] a;
         a = (n % 7 == 0) ? 16'($urandom) : 16'h1200 + 16'($urandom_range(0, 63));
         do_access(1'($urandom), 1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
      bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
      bus.line_rdata = 128'h0; bus.line_resp = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         ref_mem[i]   = 8'($urandom);
         cache_mem[i] = ref_mem[i];
      end
      ref_mem[16'h1236] = 8'hEF; cache_mem[16'h1236] = 8'hEF;
      ref_mem[16'h1237] = 8'hBE; cache_mem[16'h1237] = 8'hBE;
      test_reset;
      test_reset_mid_access;
      test_stray_resp;
      test_loads;
      test_stores;
      test_min_latency;
      test_linebuf;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
